branch_predict_unit: RTL and testbench



---
 rtl/branch_predict_unit_if.sv | 35 +++
 rtl/branch_predict_unit.sv | 124 ++++++++++++
 tb/tb_branch_predict_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/branch_predict_unit_if.sv
// Fetch/Execute bus between the pipeline and the branch predict unit.
// The pipeline side is the master; the predictor is the slave.
interface branch_predict_unit_if #(
    parameter int CNT_BITS = 16
);
    logic [31:0]         F_PC;
    logic                F_PredTaken;
    logic [31:0]         F_PredTarget;
    logic [31:0]         E_PC;
    logic [1:0]          E_PCS;
    logic [2:0]          E_Funct3;
    logic [2:0]          E_ALUFlags;
    logic [31:0]         E_Target;
    logic                E_PredTaken;
    logic [31:0]         E_PredTarget;
    logic                E_Stall;
    logic [1:0]          E_PCSrc;
    logic                E_Mispredict;
    logic [CNT_BITS-1:0] BranchCount;
    logic [CNT_BITS-1:0] MispredCount;

    modport master (
        output F_PC, E_PC, E_PCS, E_Funct3, E_ALUFlags, E_Target,
               E_PredTaken, E_PredTarget, E_Stall,
        input  F_PredTaken, F_PredTarget, E_PCSrc, E_Mispredict,
               BranchCount, MispredCount
    );

    modport slave (
        input  F_PC, E_PC, E_PCS, E_Funct3, E_ALUFlags, E_Target,
               E_PredTaken, E_PredTarget, E_Stall,
        output F_PredTaken, F_PredTarget, E_PCSrc, E_Mispredict,
               BranchCount, MispredCount
    );
endinterface

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit counters: predicts in Fetch, resolves and
// trains from Execute, and keeps saturating branch/mispredict statistics.
module branch_predict_unit #(
    parameter int IDX_BITS = 4,
    parameter int TAG_BITS = 8,
    parameter int CNT_BITS = 16
) (
    input logic CLK,
    input logic RESET,
    branch_predict_unit_if.slave bus
);
    localparam int unsigned N = 1 << IDX_BITS;

    logic [N-1:0]        valid_q;
    logic [TAG_BITS-1:0] tag_q [N];
    logic [31:0]         tgt_q [N];
    logic [1:0]          cnt_q [N];
    logic [CNT_BITS-1:0] branch_cnt;
    logic [CNT_BITS-1:0] mispred_cnt;

    logic [IDX_BITS-1:0] f_idx, e_idx;
    logic [TAG_BITS-1:0] f_tag, e_tag;
    logic                f_hit, e_hit;
    logic                is_cond, is_jal, is_jalr, is_none;
    logic                cond_taken, taken, ctl_mispred;
    logic                eq, lt, ltu;
    logic                unused_bits;

    assign f_idx = bus.F_PC[IDX_BITS+1:2];
    assign f_tag = bus.F_PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign e_idx = bus.E_PC[IDX_BITS+1:2];
    assign e_tag = bus.E_PC[IDX_BITS+TAG_BITS+1:IDX_BITS+2];
    assign unused_bits = ^{bus.F_PC[31:IDX_BITS+TAG_BITS+2], bus.F_PC[1:0],
                           bus.E_PC[31:IDX_BITS+TAG_BITS+2], bus.E_PC[1:0]};

    assign f_hit = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign e_hit = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

    assign bus.F_PredTaken  = f_hit && cnt_q[f_idx][1];
    assign bus.F_PredTarget = (f_hit && cnt_q[f_idx][1]) ? tgt_q[f_idx] : '0;

    assign is_none = (bus.E_PCS == 2'b00);
    assign is_cond = (bus.E_PCS == 2'b01);
    assign is_jal  = (bus.E_PCS == 2'b10);
    assign is_jalr = (bus.E_PCS == 2'b11);
    assign {eq, lt, ltu} = bus.E_ALUFlags;

    always_comb begin
        case (bus.E_Funct3)
            3'b000:  cond_taken = eq;
            3'b001:  cond_taken = ~eq;
            3'b100:  cond_taken = lt;
            3'b101:  cond_taken = ~lt;
            3'b110:  cond_taken = ltu;
            3'b111:  cond_taken = ~ltu;
            default: cond_taken = 1'b0;
        endcase
    end

    assign taken       = is_jal || (is_cond && cond_taken);
    assign ctl_mispred = taken ? (~bus.E_PredTaken || (bus.E_PredTarget != bus.E_Target))
                               : bus.E_PredTaken;

    always_comb begin
        bus.E_PCSrc      = 2'b00;
        bus.E_Mispredict = 1'b0;
        if (is_jalr) begin
            bus.E_PCSrc = 2'b11;
        end else if (is_cond || is_jal) begin
            if (ctl_mispred) begin
                bus.E_PCSrc      = taken ? 2'b01 : 2'b10;
                bus.E_Mispredict = 1'b1;
            end
        end else if (bus.E_PredTaken) begin
            // Fetch hit an entry aliased onto a non-control instruction.
            bus.E_PCSrc      = 2'b10;
            bus.E_Mispredict = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= 2'b01;
            end
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else if (!bus.E_Stall) begin
            if (is_cond) begin
                if (e_hit) begin
                    if (taken) begin
                        if (cnt_q[e_idx] != 2'b11) cnt_q[e_idx] <= cnt_q[e_idx] + 2'd1;
                        tgt_q[e_idx] <= bus.E_Target;
                    end else if (cnt_q[e_idx] != 2'b00) begin
                        cnt_q[e_idx] <= cnt_q[e_idx] - 2'd1;
                    end
                end else if (taken) begin
                    valid_q[e_idx] <= 1'b1;
                    tag_q[e_idx]   <= e_tag;
                    tgt_q[e_idx]   <= bus.E_Target;
                    cnt_q[e_idx]   <= 2'b10;
                end
            end else if (is_jal) begin
                valid_q[e_idx] <= 1'b1;
                tag_q[e_idx]   <= e_tag;
                tgt_q[e_idx]   <= bus.E_Target;
                cnt_q[e_idx]   <= 2'b11;
            end else if ((is_jalr || (is_none && bus.E_PredTaken)) && e_hit) begin
                valid_q[e_idx] <= 1'b0;
            end

            if ((is_cond || is_jal) && (branch_cnt != '1))
                branch_cnt <= branch_cnt + CNT_BITS'(1);
            if (bus.E_Mispredict && (mispred_cnt != '1))
                mispred_cnt <= mispred_cnt + CNT_BITS'(1);
        end
    end

    assign bus.BranchCount  = branch_cnt;
    assign bus.MispredCount = mispred_cnt;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: resolution vector table plus
// hand sequences for training, aliasing, stall, reset and counter saturation.
module tb_branch_predict_unit;
    localparam int CB = 4;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    branch_predict_unit_if #(.CNT_BITS(CB)) bus ();

    branch_predict_unit #(.IDX_BITS(4), .TAG_BITS(8), .CNT_BITS(CB)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  pcs;
        logic [2:0]  f3;
        logic [2:0]  fl;
        logic        pt;
        logic [31:0] ptgt;
        logic [31:0] tgt;
        logic [1:0]  pcsrc;
        logic        mis;
    } vec_t;

    typedef struct {
        string      nm;
        logic [1:0] pcsrc;
        logic       mis;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [CB-1:0] exp_bc = '0;
    logic [CB-1:0] exp_mc = '0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle();
        bus.E_PC = '0; bus.E_PCS = 2'b00; bus.E_Funct3 = '0; bus.E_ALUFlags = '0;
        bus.E_Target = '0; bus.E_PredTaken = 1'b0; bus.E_PredTarget = '0; bus.E_Stall = 1'b0;
    endtask

    task automatic drive_e(input string nm, input logic [31:0] pc, input logic [1:0] pcs,
                           input logic [2:0] f3, input logic [2:0] fl, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt, input logic stall,
                           input logic [1:0] xpcsrc, input logic xmis);
        exp_t e;
        bus.E_PC = pc; bus.E_PCS = pcs; bus.E_Funct3 = f3; bus.E_ALUFlags = fl;
        bus.E_Target = tgt; bus.E_PredTaken = pt; bus.E_PredTarget = ptgt; bus.E_Stall = stall;
        e.nm = nm; e.pcsrc = xpcsrc; e.mis = xmis;
        sb.push_back(e);
        if (!stall && !RESET) begin
            if ((pcs == 2'b01 || pcs == 2'b10) && exp_bc != '1) exp_bc++;
            if (xmis && exp_mc != '1) exp_mc++;
        end
    endtask

    task automatic check_e();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk({e.nm, "_pcsrc"}, 32'(bus.E_PCSrc), 32'(e.pcsrc));
            chk({e.nm, "_mis"}, 32'(bus.E_Mispredict), 32'(e.mis));
        end
    endtask

    task automatic resolve(input string nm, input logic [31:0] pc, input logic [1:0] pcs,
                           input logic [2:0] f3, input logic [2:0] fl, input logic [31:0] tgt,
                           input logic pt, input logic [31:0] ptgt, input logic stall,
                           input logic [1:0] xpcsrc, input logic xmis);
        drive_e(nm, pc, pcs, f3, fl, tgt, pt, ptgt, stall, xpcsrc, xmis);
        #3;
        check_e();
        tick();
        idle();
    endtask

    task automatic fetch_chk(input string nm, input logic [31:0] pc, input logic xt,
                             input logic [31:0] xtgt);
        bus.F_PC = pc;
        #1;
        chk({nm, "_taken"}, 32'(bus.F_PredTaken), 32'(xt));
        chk({nm, "_target"}, bus.F_PredTarget, xtgt);
    endtask

    task automatic count_chk(input string nm);
        chk({nm, "_bc"}, 32'(bus.BranchCount), 32'(exp_bc));
        chk({nm, "_mc"}, 32'(bus.MispredCount), 32'(exp_mc));
    endtask

    vec_t vt[15];

    initial begin
        // pcs, f3, flags{eq,lt,ltu}, predT, predTgt, tgt, exp pcsrc, exp mis
        vt[0]  = '{2'b01, 3'b000, 3'b100, 1'b0, 32'h0,  32'h80, 2'b01, 1'b1};
        vt[1]  = '{2'b01, 3'b000, 3'b000, 1'b0, 32'h0,  32'h80, 2'b00, 1'b0};
        vt[2]  = '{2'b01, 3'b001, 3'b000, 1'b1, 32'h80, 32'h80, 2'b00, 1'b0};
        vt[3]  = '{2'b01, 3'b001, 3'b000, 1'b1, 32'h84, 32'h80, 2'b01, 1'b1};
        vt[4]  = '{2'b01, 3'b100, 3'b010, 1'b0, 32'h0,  32'h90, 2'b01, 1'b1};
        vt[5]  = '{2'b01, 3'b101, 3'b010, 1'b1, 32'h90, 32'h90, 2'b10, 1'b1};
        vt[6]  = '{2'b01, 3'b110, 3'b001, 1'b1, 32'hA0, 32'hA0, 2'b00, 1'b0};
        vt[7]  = '{2'b01, 3'b111, 3'b000, 1'b0, 32'h0,  32'hA0, 2'b01, 1'b1};
        vt[8]  = '{2'b01, 3'b010, 3'b111, 1'b0, 32'h0,  32'hB0, 2'b00, 1'b0};
        vt[9]  = '{2'b01, 3'b011, 3'b111, 1'b1, 32'hB0, 32'hB0, 2'b10, 1'b1};
        vt[10] = '{2'b10, 3'b000, 3'b000, 1'b0, 32'h0,  32'hC0, 2'b01, 1'b1};
        vt[11] = '{2'b10, 3'b000, 3'b000, 1'b1, 32'hC0, 32'hC0, 2'b00, 1'b0};
        vt[12] = '{2'b11, 3'b000, 3'b000, 1'b1, 32'hD0, 32'hD0, 2'b11, 1'b0};
        vt[13] = '{2'b00, 3'b000, 3'b000, 1'b1, 32'hE0, 32'hE0, 2'b10, 1'b1};
        vt[14] = '{2'b00, 3'b000, 3'b000, 1'b0, 32'h0,  32'hE0, 2'b00, 1'b0};

        idle();
        bus.F_PC = '0;
        RESET = 1'b1;
        tick();
        // Resolution during reset: outputs live, update discarded.
        resolve("jal_in_reset", 32'h300, 2'b10, 3'b000, 3'b000, 32'h500, 1'b0, 32'h0, 1'b0, 2'b01, 1'b1);
        RESET = 1'b0;
        exp_bc = '0; exp_mc = '0;
        fetch_chk("reset_f100", 32'h100, 1'b0, 32'h0);
        fetch_chk("reset_f300", 32'h300, 1'b0, 32'h0);
        count_chk("reset");

        // Resolution table, all under stall so nothing trains or counts.
        for (int i = 0; i < 15; i++)
            resolve($sformatf("vec%0d", i), 32'h700, vt[i].pcs, vt[i].f3, vt[i].fl, vt[i].tgt,
                    vt[i].pt, vt[i].ptgt, 1'b1, vt[i].pcsrc, vt[i].mis);
        fetch_chk("table_nowrite", 32'h700, 1'b0, 32'h0);
        count_chk("table_stalled");

        // Stall held three cycles on a taken branch.
        for (int i = 0; i < 3; i++)
            resolve("stall_beq", 32'h180, 2'b01, 3'b000, 3'b100, 32'h88, 1'b0, 32'h0, 1'b1, 2'b01, 1'b1);
        fetch_chk("stall_f180", 32'h180, 1'b0, 32'h0);
        count_chk("stall");

        // Cold taken beq; same-cycle fetch sees the pre-update table.
        drive_e("cold_beq", 32'h100, 2'b01, 3'b000, 3'b100, 32'h80, 1'b0, 32'h0, 1'b0, 2'b01, 1'b1);
        bus.F_PC = 32'h100;
        #3;
        check_e();
        chk("cold_sameCycle_taken", 32'(bus.F_PredTaken), 32'd0);
        tick();
        idle();
        fetch_chk("cold_f100", 32'h100, 1'b1, 32'h80);
        count_chk("cold");

        // Hysteresis on bne at 0x144: allocate 10, ->11, ->10, ->01.
        resolve("hys_t1", 32'h144, 2'b01, 3'b001, 3'b000, 32'h40, 1'b0, 32'h0,  1'b0, 2'b01, 1'b1);
        resolve("hys_t2", 32'h144, 2'b01, 3'b001, 3'b000, 32'h40, 1'b1, 32'h40, 1'b0, 2'b00, 1'b0);
        fetch_chk("hys_strong", 32'h144, 1'b1, 32'h40);
        resolve("hys_nt1", 32'h144, 2'b01, 3'b001, 3'b100, 32'h40, 1'b1, 32'h40, 1'b0, 2'b10, 1'b1);
        fetch_chk("hys_weakT", 32'h144, 1'b1, 32'h40);
        count_chk("hys");
        resolve("hys_nt2", 32'h144, 2'b01, 3'b001, 3'b100, 32'h40, 1'b1, 32'h40, 1'b0, 2'b10, 1'b1);
        fetch_chk("hys_weakNT", 32'h144, 1'b0, 32'h0);

        // jal overwrites index 0, then an aliased non-control invalidates it.
        resolve("jal_200", 32'h200, 2'b10, 3'b000, 3'b000, 32'h400, 1'b0, 32'h0, 1'b0, 2'b01, 1'b1);
        fetch_chk("jal_f200", 32'h200, 1'b1, 32'h400);
        fetch_chk("jal_evict_f100", 32'h100, 1'b0, 32'h0);
        resolve("alias_200", 32'h200, 2'b00, 3'b000, 3'b000, 32'h0, 1'b1, 32'h400, 1'b0, 2'b10, 1'b1);
        fetch_chk("alias_f200", 32'h200, 1'b0, 32'h0);

        // jalr invalidates a matching entry without flagging a mispredict.
        resolve("jal_208", 32'h208, 2'b10, 3'b000, 3'b000, 32'h600, 1'b0, 32'h0, 1'b0, 2'b01, 1'b1);
        fetch_chk("jal_f208", 32'h208, 1'b1, 32'h600);
        resolve("jalr_208", 32'h208, 2'b11, 3'b000, 3'b000, 32'h0, 1'b1, 32'h600, 1'b0, 2'b11, 1'b0);
        fetch_chk("jalr_f208", 32'h208, 1'b0, 32'h0);
        resolve("f3_010", 32'h20C, 2'b01, 3'b010, 3'b111, 32'h10, 1'b0, 32'h0, 1'b0, 2'b00, 1'b0);
        fetch_chk("f3_010_nowrite", 32'h20C, 1'b0, 32'h0);
        count_chk("after_jalr");

        // Saturation of both 4-bit statistics counters.
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        exp_bc = '0; exp_mc = '0;
        count_chk("sat_reset");
        for (int i = 0; i < 20; i++)
            resolve("sat_beq", 32'h300, 2'b01, 3'b000, 3'b100, 32'h500, 1'b0, 32'h0, 1'b0, 2'b01, 1'b1);
        count_chk("sat_model");
        chk("sat_bc_max", 32'(bus.BranchCount), 32'hF);
        chk("sat_mc_max", 32'(bus.MispredCount), 32'hF);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
